// File: rtl/boot_loader_seq.sv
// ---------------------------------------------------------------------------
// boot_loader_seq
//
// Boot sequencer sitting behind the secure boot ROM. After reset it starts the
// ROM hash check, waits for the hash to pass, verifies the boot signature in
// ROM word 0, copies ROM words 1..COPY_WORDS into instruction memory and only
// then releases the RISC-V core from reset at BOOT_PC. Any failure parks the
// sequencer in FAIL with the core held in reset until the next rst_n.
//
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   rom_cs/rom_read_en ROM read strobe (address presented this cycle,
//                      rom_data valid the next cycle)
//   rom_addr           ROM byte address (word index << 2)
//   rom_data           registered ROM read data
//   rom_hash_valid     ROM hash check passed (sampled only while waiting)
//   rom_boot_ready     informational, not used for sequencing
//   imem_we/addr/wdata IMEM write request, held until imem_ready
//   imem_ready         IMEM accepts a write when imem_we && imem_ready
//   core_rst_n         core reset, active-low
//   boot_pc            core reset vector (constant BOOT_PC)
//   boot_done          sticky success flag
//   boot_fail          sticky failure flag
//   fail_code          0 none, 1 hash timeout, 2 bad signature
// ---------------------------------------------------------------------------
module boot_loader_seq #(
  parameter int unsigned COPY_WORDS     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] SIGNATURE      = 32'hCAFE_BABE,
  parameter logic [31:0] IMEM_BASE      = 32'h0000_0000,
  parameter logic [31:0] BOOT_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        rom_cs,
  output logic        rom_read_en,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        rom_hash_valid,
  input  logic        rom_boot_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  input  logic        imem_ready,
  output logic        core_rst_n,
  output logic [31:0] boot_pc,
  output logic        boot_done,
  output logic        boot_fail,
  output logic [1:0]  fail_code
);

  localparam int unsigned         CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]          LAST_IDX = 8'(COPY_WORDS);

  typedef enum logic [3:0] {
    IDLE,
    WAIT_HASH,
    SIG_RD,
    SIG_CHK,
    RD,
    CAPT,
    WR,
    RELEASE,
    DONE,
    FAIL
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next values of the registered outputs.
  logic        rom_rd_d;
  logic [31:0] rom_addr_d;
  logic        imem_we_d;
  logic [31:0] imem_addr_d;
  logic [31:0] imem_wdata_d;
  logic        released_d;
  logic        fail_d;
  logic [1:0]  fail_code_d;

  // The reset vector never changes, so it needs no register.
  assign boot_pc = BOOT_PC;

  // rom_boot_ready is purely informational and does not steer the sequence.
  logic unused_boot_ready;
  assign unused_boot_ready = rom_boot_ready;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    fail_code_d  = fail_code;
    rom_addr_d   = rom_addr;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;

    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = WAIT_HASH;
      end
      WAIT_HASH: begin
        // A hash pass on the final allowed cycle still counts as a pass.
        if (rom_hash_valid) begin
          cnt_d   = '0;
          state_d = SIG_RD;
        end else if (cnt_q == CNT_LAST) begin
          fail_code_d = 2'd1;
          state_d     = FAIL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SIG_RD: state_d = SIG_CHK;
      SIG_CHK: begin
        if (rom_data == SIGNATURE) begin
          idx_d   = 8'd1;
          state_d = RD;
        end else begin
          fail_code_d = 2'd2;
          state_d     = FAIL;
        end
      end
      RD: state_d = CAPT;
      CAPT: begin
        // imem_wdata doubles as the write buffer: it holds until acceptance.
        imem_wdata_d = rom_data;
        imem_addr_d  = IMEM_BASE + {22'd0, idx_q - 8'd1, 2'b00};
        state_d      = WR;
      end
      WR: begin
        if (imem_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = RELEASE;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = RD;
          end
        end
      end
      RELEASE: state_d = DONE;
      DONE:    state_d = DONE;
      FAIL:    state_d = FAIL;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so each state
    // sees its own output values during the cycle it occupies.
    rom_rd_d = (state_d == WAIT_HASH) || (state_d == SIG_RD) || (state_d == RD);
    if ((state_d == WAIT_HASH) || (state_d == SIG_RD)) begin
      rom_addr_d = '0;
    end else if (state_d == RD) begin
      rom_addr_d = {22'd0, idx_d, 2'b00};
    end
    imem_we_d  = (state_d == WR);
    released_d = (state_d == RELEASE) || (state_d == DONE);
    fail_d     = (state_d == FAIL);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      rom_cs      <= 1'b0;
      rom_read_en <= 1'b0;
      rom_addr    <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      core_rst_n  <= 1'b0;
      boot_done   <= 1'b0;
      boot_fail   <= 1'b0;
      fail_code   <= 2'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      rom_cs      <= rom_rd_d;
      rom_read_en <= rom_rd_d;
      rom_addr    <= rom_addr_d;
      imem_we     <= imem_we_d;
      imem_addr   <= imem_addr_d;
      imem_wdata  <= imem_wdata_d;
      core_rst_n  <= released_d;
      boot_done   <= released_d;
      boot_fail   <= fail_d;
      fail_code   <= fail_code_d;
    end
  end

endmodule
